// File: rtl/seven_segment_chain_serializer_pkg.sv
// Shared definitions for the seven-segment chain serializer: CTRL register
// bit positions, FSM state encoding and the per-digit width.
package seven_seg_pkg;

    localparam int unsigned DIGIT_W      = 8;

    localparam int unsigned CTRL_GO      = 0;
    localparam int unsigned CTRL_AUTO    = 1;
    localparam int unsigned CTRL_BUSY    = 8;
    localparam int unsigned CTRL_PENDING = 9;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LOAD,
        ST_SHIFT_LO,
        ST_SHIFT_HI,
        ST_LATCH
    } state_t;

endpackage

// File: rtl/seven_segment_chain_serializer_if.sv
// Avalon-MM slave bus bundle for the serializer register file.
interface seven_segment_chain_serializer_if #(
    parameter int unsigned ADDR_W = 3
);
    logic              chipselect;
    logic              read;
    logic              write;
    logic [ADDR_W-1:0] address;
    logic [3:0]        byteenable;
    logic [31:0]       writedata;
    logic [31:0]       readdata;

    modport master (
        output chipselect, read, write, address, byteenable, writedata,
        input  readdata
    );

    modport slave (
        input  chipselect, read, write, address, byteenable, writedata,
        output readdata
    );
endinterface

// File: rtl/seven_segment_chain_serializer_bit_timer.sv
// Phase timer: counts CLK_DIV cycles per FSM phase and flags the last one.
// Reloaded whenever the FSM enters a new state.
module seven_segment_bit_timer #(
    parameter int unsigned CLK_DIV = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic clear_i,
    output logic tick_o
);
    localparam logic [7:0] RELOAD = 8'(CLK_DIV - 1);

    logic [7:0] cnt_q, cnt_d;

    // Reload on state entry, otherwise count down and park at zero.
    always_comb begin
        cnt_d = cnt_q;
        if (clear_i) begin
            cnt_d = RELOAD;
        end else if (cnt_q != '0) begin
            cnt_d = cnt_q - 8'd1;
        end
    end

    // Counter register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign tick_o = (cnt_q == '0);

endmodule

// File: rtl/seven_segment_chain_serializer.sv
// Seven-segment chain serializer: Avalon-MM register file of digit patterns
// that are shifted MSB-first (highest digit first) into a daisy chain of
// 8-bit shift/storage registers, followed by a latch strobe.
module seven_segment_chain_serializer
    import seven_seg_pkg::*;
#(
    parameter int unsigned NUM_DIGITS = 4,
    parameter int unsigned CLK_DIV    = 4,
    parameter int unsigned ADDR_W     = 3
) (
    input  logic                                 clock,
    input  logic                                 reset,
    seven_segment_chain_serializer_if.slave      bus,
    output logic                                 ser_data,
    output logic                                 ser_clk,
    output logic                                 ser_latch,
    output logic                                 busy
);
    localparam int unsigned       TOTAL     = NUM_DIGITS * DIGIT_W;
    localparam int unsigned       CNT_W     = $clog2(TOTAL);
    localparam logic [ADDR_W-1:0] CTRL_ADDR = ADDR_W'(NUM_DIGITS);
    localparam logic [CNT_W-1:0]  LAST_BIT  = CNT_W'(TOTAL - 1);

    state_t               state_q, state_d;
    logic [DIGIT_W-1:0]   digit_q [NUM_DIGITS];
    logic                 auto_q;
    logic                 pending_q, pending_d;
    logic [TOTAL-1:0]     shift_q, shift_d;
    logic [TOTAL-1:0]     snap;
    logic [CNT_W-1:0]     bit_cnt_q, bit_cnt_d;
    logic                 ser_data_q, ser_clk_q, ser_latch_q, busy_q;
    logic                 tick, timer_clear;

    logic wr_lane0, ctrl_sel, digit_sel, go_req, start_req;
    logic unused_bus;

    assign wr_lane0  = bus.chipselect & bus.write & bus.byteenable[0];
    assign ctrl_sel  = (bus.address == CTRL_ADDR);
    assign digit_sel = (bus.address < CTRL_ADDR);
    assign go_req    = wr_lane0 & ctrl_sel & bus.writedata[CTRL_GO];
    assign start_req = go_req | (wr_lane0 & digit_sel & auto_q);

    assign unused_bus = ^{bus.read, bus.writedata[31:DIGIT_W], bus.byteenable[3:1]};

    // Register file: digit patterns and the AUTO mode bit.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            for (int unsigned k = 0; k < NUM_DIGITS; k++) begin
                digit_q[k] <= '0;
            end
            auto_q <= 1'b0;
        end else if (wr_lane0) begin
            for (int unsigned k = 0; k < NUM_DIGITS; k++) begin
                if (bus.address == ADDR_W'(k)) begin
                    digit_q[k] <= bus.writedata[DIGIT_W-1:0];
                end
            end
            if (ctrl_sel) begin
                auto_q <= bus.writedata[CTRL_AUTO];
            end
        end
    end

    // Zero-wait-state read mux; GO always reads back as zero.
    always_comb begin
        bus.readdata = '0;
        for (int unsigned k = 0; k < NUM_DIGITS; k++) begin
            if (bus.address == ADDR_W'(k)) begin
                bus.readdata[DIGIT_W-1:0] = digit_q[k];
            end
        end
        if (ctrl_sel) begin
            bus.readdata[CTRL_AUTO]    = auto_q;
            bus.readdata[CTRL_BUSY]    = busy_q;
            bus.readdata[CTRL_PENDING] = pending_q;
        end
    end

    // Snapshot image: highest digit in the top byte so it leaves first.
    always_comb begin
        snap = '0;
        for (int unsigned k = 0; k < NUM_DIGITS; k++) begin
            snap[k*DIGIT_W +: DIGIT_W] = digit_q[k];
        end
    end

    // Transfer sequencing, request collapsing and shift-register update.
    always_comb begin
        state_d   = state_q;
        pending_d = pending_q;
        shift_d   = shift_q;
        bit_cnt_d = bit_cnt_q;

        if (start_req && state_q != ST_IDLE) begin
            pending_d = 1'b1;
        end

        case (state_q)
            ST_IDLE: begin
                if (start_req || pending_q) begin
                    state_d = ST_LOAD;
                end
            end
            ST_LOAD: begin
                state_d   = ST_SHIFT_LO;
                shift_d   = snap;
                bit_cnt_d = '0;
                // A request landing on the snapshot edge missed the snapshot,
                // so it has to survive the clear.
                pending_d = start_req;
            end
            ST_SHIFT_LO: begin
                if (tick) begin
                    state_d = ST_SHIFT_HI;
                end
            end
            ST_SHIFT_HI: begin
                if (tick) begin
                    if (bit_cnt_q == LAST_BIT) begin
                        state_d = ST_LATCH;
                    end else begin
                        state_d   = ST_SHIFT_LO;
                        bit_cnt_d = bit_cnt_q + CNT_W'(1);
                        shift_d   = {shift_q[TOTAL-2:0], 1'b0};
                    end
                end
            end
            ST_LATCH: begin
                if (tick) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    assign timer_clear = (state_d != state_q);

    seven_segment_bit_timer #(
        .CLK_DIV (CLK_DIV)
    ) u_bit_timer (
        .clk     (clock),
        .rst     (reset),
        .clear_i (timer_clear),
        .tick_o  (tick)
    );

    // FSM state, shifter and registered chain outputs (decoded from next state
    // so the pins line up with the state register and never glitch).
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q     <= ST_IDLE;
            pending_q   <= 1'b0;
            shift_q     <= '0;
            bit_cnt_q   <= '0;
            ser_data_q  <= 1'b0;
            ser_clk_q   <= 1'b0;
            ser_latch_q <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            pending_q   <= pending_d;
            shift_q     <= shift_d;
            bit_cnt_q   <= bit_cnt_d;
            ser_data_q  <= (state_d == ST_SHIFT_LO || state_d == ST_SHIFT_HI) ?
                           shift_d[TOTAL-1] : 1'b0;
            ser_clk_q   <= (state_d == ST_SHIFT_HI);
            ser_latch_q <= (state_d == ST_LATCH);
            busy_q      <= (state_d != ST_IDLE);
        end
    end

    assign ser_data  = ser_data_q;
    assign ser_clk   = ser_clk_q;
    assign ser_latch = ser_latch_q;
    assign busy      = busy_q;

endmodule

// File: tb/tb_seven_segment_chain_serializer.sv
// Bench for the seven-segment chain serializer: a 4-digit/CLK_DIV=2 instance
// and a 1-digit/CLK_DIV=1 instance, with a monitor that reconstructs the
// serial stream, latch pulses and busy windows from the pins.
module tb_seven_segment_chain_serializer;

    logic clock = 1'b0;
    logic reset;
    always #5 clock = ~clock;

    seven_segment_chain_serializer_if #(.ADDR_W(3)) bus_a ();
    seven_segment_chain_serializer_if #(.ADDR_W(1)) bus_b ();

    logic sd_a, sc_a, sl_a, bz_a;
    logic sd_b, sc_b, sl_b, bz_b;

    seven_segment_chain_serializer #(.NUM_DIGITS(4), .CLK_DIV(2), .ADDR_W(3)) dut_a (
        .clock(clock), .reset(reset), .bus(bus_a),
        .ser_data(sd_a), .ser_clk(sc_a), .ser_latch(sl_a), .busy(bz_a)
    );

    seven_segment_chain_serializer #(.NUM_DIGITS(1), .CLK_DIV(1), .ADDR_W(1)) dut_b (
        .clock(clock), .reset(reset), .bus(bus_b),
        .ser_data(sd_b), .ser_clk(sc_b), .ser_latch(sl_b), .busy(bz_b)
    );

    logic [1:0] m_sd, m_sc, m_sl, m_bz;
    assign m_sd = {sd_b, sd_a};
    assign m_sc = {sc_b, sc_a};
    assign m_sl = {sl_b, sl_a};
    assign m_bz = {bz_b, bz_a};

    // Monitor state per instance
    logic [63:0] got_word [2] = '{64'd0, 64'd0};
    int got_cnt [2], lat_pulses [2], lat_run [2], lat_len [2];
    int busy_rises [2], busy_run [2], busy_len [2], prev_busy_len [2];
    int idle_run [2], gap_len [2];
    logic [1:0] p_sc = '0, p_sl = '0, p_bz = '0;

    always @(negedge clock) begin
        for (int i = 0; i < 2; i++) begin
            if (m_sc[i] && !p_sc[i]) begin
                got_word[i] <= {got_word[i][62:0], m_sd[i]};
                got_cnt[i]  <= got_cnt[i] + 1;
            end
            if (m_sl[i]) begin
                if (!p_sl[i]) lat_pulses[i] <= lat_pulses[i] + 1;
                lat_run[i] <= lat_run[i] + 1;
            end else if (p_sl[i]) begin
                lat_len[i] <= lat_run[i];
                lat_run[i] <= 0;
            end
            if (m_bz[i]) begin
                if (!p_bz[i]) begin
                    busy_rises[i] <= busy_rises[i] + 1;
                    gap_len[i]    <= idle_run[i];
                    busy_run[i]   <= 1;
                end else begin
                    busy_run[i] <= busy_run[i] + 1;
                end
            end else begin
                if (p_bz[i]) begin
                    prev_busy_len[i] <= busy_len[i];
                    busy_len[i]      <= busy_run[i];
                    idle_run[i]      <= 1;
                end else begin
                    idle_run[i] <= idle_run[i] + 1;
                end
            end
        end
        p_sc <= m_sc;
        p_sl <= m_sl;
        p_bz <= m_bz;
    end

    // Reference model: the digit registers as the bench believes them
    logic [7:0] mdl [2][4];
    int n_total = 0, n_pass = 0, n_fail = 0;

    function automatic int ndig(input int sel);
        return (sel == 0) ? 4 : 1;
    endfunction

    function automatic int cdiv(input int sel);
        return (sel == 0) ? 2 : 1;
    endfunction

    // Serial image: highest digit first, MSB first within a digit
    function automatic logic [63:0] exp_word(input int sel);
        logic [63:0] w = '0;
        for (int d = ndig(sel) - 1; d >= 0; d--) w = (w << 8) | 64'(mdl[sel][d]);
        return w;
    endfunction

    function automatic int exp_busy(input int sel);
        return 1 + 2 * cdiv(sel) * 8 * ndig(sel) + cdiv(sel);
    endfunction

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic bus_wr(input int sel, input int a, input logic [31:0] d, input logic [3:0] be);
        @(negedge clock);
        if (sel == 0) begin
            bus_a.chipselect = 1'b1; bus_a.write = 1'b1; bus_a.address = 3'(a);
            bus_a.writedata = d; bus_a.byteenable = be;
        end else begin
            bus_b.chipselect = 1'b1; bus_b.write = 1'b1; bus_b.address = 1'(a);
            bus_b.writedata = d; bus_b.byteenable = be;
        end
        @(negedge clock);
        bus_a.chipselect = 1'b0; bus_a.write = 1'b0;
        bus_b.chipselect = 1'b0; bus_b.write = 1'b0;
    endtask

    task automatic bus_rd(input int sel, input int a, output logic [31:0] d);
        @(negedge clock);
        if (sel == 0) begin
            bus_a.chipselect = 1'b1; bus_a.read = 1'b1; bus_a.address = 3'(a);
            #1 d = bus_a.readdata;
        end else begin
            bus_b.chipselect = 1'b1; bus_b.read = 1'b1; bus_b.address = 1'(a);
            #1 d = bus_b.readdata;
        end
        bus_a.chipselect = 1'b0; bus_a.read = 1'b0;
        bus_b.chipselect = 1'b0; bus_b.read = 1'b0;
    endtask

    task automatic set_digit(input int sel, input int k, input logic [7:0] v);
        logic [31:0] d;
        d = $urandom();
        d[7:0] = v;
        bus_wr(sel, k, d, 4'hF);
        mdl[sel][k] = v;
    endtask

    // Wait for busy to rise (if not already) then fall, bounded both ways
    task automatic wait_done(input int sel, input string tag);
        int n;
        n = 0;
        while (!m_bz[sel] && n < 20) begin @(negedge clock); n++; end
        while (m_bz[sel] && n < 5000) begin @(negedge clock); n++; end
        #1;
        chk({tag, "_done"}, 64'(n < 5000 && !m_bz[sel]), 64'd1);
    endtask

    task automatic run_go(input int sel, input string tag);
        int b_bits, b_lat;
        logic [31:0] rd;
        logic [63:0] mask;
        b_bits = got_cnt[sel];
        b_lat  = lat_pulses[sel];
        bus_wr(sel, ndig(sel), 32'h1, 4'h1);
        bus_rd(sel, ndig(sel), rd);
        chk({tag, "_ctrl_busy"}, 64'(rd), 64'h100);
        wait_done(sel, tag);
        mask = (64'd1 << (8 * ndig(sel))) - 64'd1;
        chk({tag, "_nbits"}, 64'(got_cnt[sel] - b_bits), 64'(8 * ndig(sel)));
        chk({tag, "_stream"}, got_word[sel] & mask, exp_word(sel));
        chk({tag, "_latches"}, 64'(lat_pulses[sel] - b_lat), 64'd1);
        chk({tag, "_latch_len"}, 64'(lat_len[sel]), 64'(cdiv(sel)));
        chk({tag, "_busy_len"}, 64'(busy_len[sel]), 64'(exp_busy(sel)));
    endtask

    logic [31:0] rd;
    logic [63:0] w1, w2;
    int b0, r0, lp, n;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        bus_a.chipselect = 0; bus_a.read = 0; bus_a.write = 0; bus_a.address = '0;
        bus_a.byteenable = '0; bus_a.writedata = '0;
        bus_b.chipselect = 0; bus_b.read = 0; bus_b.write = 0; bus_b.address = '0;
        bus_b.byteenable = '0; bus_b.writedata = '0;
        for (int s = 0; s < 2; s++) for (int k = 0; k < 4; k++) mdl[s][k] = 8'h00;
        reset = 1'b1;
        repeat (3) @(negedge clock);
        chk("rst_pins_a", 64'({sd_a, sc_a, sl_a, bz_a}), 64'd0);
        chk("rst_pins_b", 64'({sd_b, sc_b, sl_b, bz_b}), 64'd0);
        reset = 1'b0;
        bus_rd(0, 4, rd); chk("rst_ctrl", 64'(rd), 64'd0);
        bus_rd(0, 2, rd); chk("rst_digit2", 64'(rd), 64'd0);

        // Byte-lane gating and unmapped addresses
        bus_wr(0, 1, 32'h55, 4'b1110);
        bus_rd(0, 1, rd); chk("be_gated", 64'(rd), 64'd0);
        bus_wr(0, 7, 32'hFFFF_FFFF, 4'hF);
        bus_rd(0, 7, rd); chk("addr7_read", 64'(rd), 64'd0);
        bus_rd(0, 4, rd); chk("addr7_no_ctrl", 64'(rd), 64'd0);

        // Directed pattern
        set_digit(0, 3, 8'hA5); set_digit(0, 2, 8'h3C);
        set_digit(0, 1, 8'hFF); set_digit(0, 0, 8'h01);
        bus_rd(0, 3, rd); chk("digit3_rd", 64'(rd), 64'hA5);
        run_go(0, "dir");
        bus_rd(0, 4, rd); chk("go_selfclear", 64'(rd), 64'd0);

        // Random patterns
        for (int t = 0; t < 3; t++) begin
            for (int k = 0; k < 4; k++) set_digit(0, k, 8'($urandom()));
            bus_rd(0, 1, rd); chk("rnd_digit1_rd", 64'(rd), 64'(mdl[0][1]));
            run_go(0, "rnd");
        end

        // AUTO mode with a mid-transfer rewrite
        bus_wr(0, 4, 32'h2, 4'h1);
        bus_rd(0, 4, rd); chk("auto_rd", 64'(rd), 64'h2);
        b0 = got_cnt[0]; r0 = busy_rises[0];
        set_digit(0, 0, 8'h7E);
        w1 = exp_word(0);
        repeat (20) @(negedge clock);
        set_digit(0, 2, 8'($urandom()));
        w2 = exp_word(0);
        bus_rd(0, 4, rd); chk("auto_pending", 64'(rd), 64'h302);
        wait_done(0, "auto1");
        wait_done(0, "auto2");
        chk("auto_rises", 64'(busy_rises[0] - r0), 64'd2);
        chk("auto_gap", 64'(gap_len[0]), 64'd1);
        chk("auto_nbits", 64'(got_cnt[0] - b0), 64'd64);
        chk("auto_stream", got_word[0], {w1[31:0], w2[31:0]});
        chk("auto_busy1", 64'(prev_busy_len[0]), 64'(exp_busy(0)));
        chk("auto_busy2", 64'(busy_len[0]), 64'(exp_busy(0)));
        bus_wr(0, 4, 32'h0, 4'h1);
        bus_rd(0, 4, rd); chk("auto_off", 64'(rd), 64'd0);

        // Three GO writes during one transfer collapse to one follow-on
        r0 = busy_rises[0];
        bus_wr(0, 4, 32'h1, 4'h1);
        repeat (10) @(negedge clock);
        bus_wr(0, 4, 32'h1, 4'h1);
        repeat (30) @(negedge clock);
        bus_wr(0, 4, 32'h1, 4'h1);
        repeat (30) @(negedge clock);
        bus_wr(0, 4, 32'h1, 4'h1);
        wait_done(0, "multi1");
        wait_done(0, "multi2");
        repeat (200) @(negedge clock);
        chk("multi_rises", 64'(busy_rises[0] - r0), 64'd2);
        chk("multi_gap", 64'(gap_len[0]), 64'd1);

        // GO landing on the final LATCH cycle must not be lost
        r0 = busy_rises[0];
        bus_wr(0, 4, 32'h1, 4'h1);
        repeat (130) @(negedge clock);
        chk("latexit_in_latch", 64'(sl_a), 64'd1);
        bus_a.chipselect = 1'b1; bus_a.write = 1'b1; bus_a.address = 3'd4;
        bus_a.writedata = 32'h1; bus_a.byteenable = 4'h1;
        @(negedge clock);
        bus_a.chipselect = 1'b0; bus_a.write = 1'b0;
        chk("latexit_idle", 64'(bz_a), 64'd0);
        wait_done(0, "latexit2");
        chk("latexit_rises", 64'(busy_rises[0] - r0), 64'd2);
        chk("latexit_gap", 64'(gap_len[0]), 64'd1);

        // Reset mid-transfer
        for (int k = 0; k < 4; k++) set_digit(0, k, 8'hC3);
        b0 = got_cnt[0]; lp = lat_pulses[0];
        bus_wr(0, 4, 32'h1, 4'h1);
        n = 0;
        while (got_cnt[0] - b0 < 10 && n < 200) begin @(negedge clock); n++; end
        chk("rst_reach_bit10", 64'(n < 200), 64'd1);
        reset = 1'b1;
        #1;
        chk("rst_mid_pins", 64'({sd_a, sc_a, sl_a, bz_a}), 64'd0);
        bus_a.address = 3'd0;
        #1 chk("rst_mid_digit0", 64'(bus_a.readdata), 64'd0);
        bus_a.address = 3'd3;
        #1 chk("rst_mid_digit3", 64'(bus_a.readdata), 64'd0);
        @(negedge clock);
        reset = 1'b0;
        for (int k = 0; k < 4; k++) mdl[0][k] = 8'h00;
        r0 = busy_rises[0];
        repeat (300) @(negedge clock);
        chk("rst_no_latch", 64'(lat_pulses[0]), 64'(lp));
        chk("rst_no_restart", 64'(busy_rises[0]), 64'(r0));

        // Single digit, CLK_DIV=1
        set_digit(1, 0, 8'h80);
        run_go(1, "b80");
        for (int t = 0; t < 2; t++) begin
            set_digit(1, 0, 8'($urandom()));
            bus_rd(1, 0, rd); chk("b_digit_rd", 64'(rd), 64'(mdl[1][0]));
            run_go(1, "brnd");
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/seven_segment_chain_serializer.md
SEVEN_SEGMENT_CHAIN_SERIALIZER -- requirements
Module: seven_segment_chain_serializer

Interface
REQ-001 Parameter NUM_DIGITS, default 4: number of daisy-chained 8-bit segment drivers, 1..16.
REQ-002 Parameter CLK_DIV, default 4: system clocks per ser_clk half-period, 1..255.
REQ-003 Parameter ADDR_W, default 3: Avalon word-address width, equal to clog2(NUM_DIGITS+1).
REQ-004 clock  in  1  system clock, all logic on rising edge.
REQ-005 reset  in  1  asynchronous, active-high reset.
REQ-006 chipselect, read, write  in  1 each  Avalon-MM slave controls; zero wait states.
REQ-007 address  in  ADDR_W  word address.
REQ-008 byteenable  in  4  byte lanes of writedata.
REQ-009 writedata  in  32  write data.
REQ-010 readdata  out  32  read data, combinational from address.
REQ-011 ser_data  out  1  serial segment data to chain.
REQ-012 ser_clk  out  1  shift clock to chain.
REQ-013 ser_latch  out  1  storage-register latch strobe to chain.
REQ-014 busy  out  1  transfer in progress.

Function
REQ-015 Address k < NUM_DIGITS: DIGIT[k], 8-bit segment pattern in bits 7:0; write only when chipselect&write&byteenable[0]; reads return zero-extended value.
REQ-016 Address NUM_DIGITS: CTRL; bit0 GO (write-1, self-clearing, reads 0), bit1 AUTO (R/W, needs byteenable[0]), bit8 BUSY (read-only), bit9 PENDING (read-only).
REQ-017 Other addresses: writes ignored, reads return 0.
REQ-018 Start request: GO write, or any DIGIT write while AUTO=1.
REQ-019 States: IDLE, LOAD, SHIFT_LO, SHIFT_HI, LATCH.
REQ-020 IDLE -> LOAD on start request or PENDING=1; LOAD lasts 1 cycle and snapshots all DIGIT registers into an NUM_DIGITS*8-bit shift register, clears PENDING.
REQ-021 Bit order: DIGIT[NUM_DIGITS-1] first, MSB first within each digit; DIGIT[0] bit0 last.
REQ-022 SHIFT_LO: ser_clk=0, ser_data=current bit, CLK_DIV cycles; SHIFT_HI: ser_clk=1, CLK_DIV cycles; bit counter advances on SHIFT_HI exit.
REQ-023 After bit NUM_DIGITS*8-1: LATCH for CLK_DIV cycles with ser_latch=1, ser_clk=0, then IDLE.
REQ-024 busy=1 in every state except IDLE; busy duration = 1 + 2*CLK_DIV*8*NUM_DIGITS + CLK_DIV cycles.
REQ-025 Start request while busy sets PENDING; multiple requests collapse to one; new transfer begins in the cycle after LATCH ends (IDLE for exactly 1 cycle).
REQ-026 DIGIT writes during a transfer update registers immediately but do not alter the in-flight snapshot.
REQ-027 Start request coincident with LATCH exit sets PENDING (no lost request).
REQ-028 ser_data, ser_clk, ser_latch are registered outputs, glitch-free.

Reset
REQ-029 reset asserted: state=IDLE, DIGIT[*]=0, AUTO=0, PENDING=0, counters=0, ser_data=0, ser_clk=0, ser_latch=0, busy=0.
REQ-030 reset mid-transfer aborts immediately with no latch pulse; after release no transfer starts until a new request.

Structure
REQ-031 Shared package seven_seg_pkg holds: CTRL bit positions (GO, AUTO, BUSY, PENDING), state enum, digit width constant 8.
REQ-032 One sub-module seven_segment_bit_timer: CLK_DIV down-counter producing a one-cycle phase tick, cleared on state entry.

Verification
REQ-033 NUM_DIGITS=4, CLK_DIV=2: DIGIT[3..0]=0xA5,0x3C,0xFF,0x01, GO -> 32 bits on ser_clk rising edges = A5 3C FF 01 MSB-first, one 2-cycle ser_latch, busy high 131 cycles.
REQ-034 AUTO=1, write DIGIT[0]=0x7E -> transfer starts without GO; second DIGIT write mid-transfer -> PENDING=1, back-to-back transfer with 1 IDLE cycle, second carries new data.
REQ-035 Three GO writes during one transfer -> exactly one follow-on transfer.
REQ-036 Write DIGIT[1]=0x55 with byteenable=4'b1110 -> DIGIT[1] unchanged; read address 7 -> 0.
REQ-037 reset asserted at bit 10 -> outputs 0 at once, busy=0, no ser_latch pulse, DIGIT reads 0.
REQ-038 NUM_DIGITS=1, CLK_DIV=1: GO with DIGIT[0]=0x80 -> ser_data high only on first ser_clk rise, busy 18 cycles.
